// File: rtl/coin_acceptor_pkg.sv
// rtl/coin_acceptor_pkg.sv - shared coin codes and acceptor state encoding
package coin_acceptor_pkg;

    typedef logic [1:0] coin_t;

    localparam coin_t COIN_NONE = 2'b00;
    localparam coin_t COIN_5    = 2'b01;
    localparam coin_t COIN_10   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_QUAL    = 3'd1,
        ST_EMIT    = 3'd2,
        ST_REJECT  = 3'd3,
        ST_RELEASE = 3'd4
    } acc_state_t;

endpackage

// File: rtl/coin_acceptor_if.sv
// rtl/coin_acceptor_if.sv - sensor/inhibit inputs and coin/reject/fault outputs
// master: sensor side (drives raw sensors and inhibit, observes results)
// slave:  the acceptor (samples sensors and inhibit, drives coin/reject/fault)
interface coin_acceptor_if;
    import coin_acceptor_pkg::*;

    logic  coin5_raw;
    logic  coin10_raw;
    logic  inhibit;
    coin_t coin;
    logic  reject;
    logic  fault;

    modport master (
        output coin5_raw, coin10_raw, inhibit,
        input  coin, reject, fault
    );

    modport slave (
        input  coin5_raw, coin10_raw, inhibit,
        output coin, reject, fault
    );
endinterface

// File: rtl/coin_acceptor_sync2.sv
// rtl/coin_acceptor_sync2.sv - two-flop synchroniser with async active-high reset
// Ports: clk, rst (async, active-high), d (asynchronous input), q (synchronised)
module coin_acceptor_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - debounced coin sensor front end with reject and stuck detection
// Ports: clk, rst (async, active-high), bus (slave modport):
//   coin5_raw/coin10_raw raw sensors, inhibit, coin (1-cycle code),
//   reject (1-cycle gate pulse), fault (sticky stuck-sensor flag)
module coin_acceptor
    import coin_acceptor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STUCK_CYCLES    = 4096
) (
    input  logic            clk,
    input  logic            rst,
    coin_acceptor_if.slave  bus
);
    localparam int CW = $clog2(STUCK_CYCLES + 1);
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] DEB_QUAL  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DEB_REL   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] STUCK_MAX = CW'(STUCK_CYCLES);

    logic s5, s10;

    coin_acceptor_sync2 u_sync5 (
        .clk (clk),
        .rst (rst),
        .d   (bus.coin5_raw),
        .q   (s5)
    );

    coin_acceptor_sync2 u_sync10 (
        .clk (clk),
        .rst (rst),
        .d   (bus.coin10_raw),
        .q   (s10)
    );

    acc_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] stuck_q, stuck_d;
    coin_t         type_q, type_d;
    coin_t         coin_q, coin_d;
    logic          reject_q, reject_d;
    logic          fault_q, fault_d;

    // Sensor that started the current coin versus the other one.
    logic latched_hi, other_hi;
    assign latched_hi = (type_q == COIN_5) ? s5  : s10;
    assign other_hi   = (type_q == COIN_5) ? s10 : s5;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stuck_d  = stuck_q;
        type_d   = type_q;
        coin_d   = COIN_NONE;
        reject_d = 1'b0;
        fault_d  = fault_q;

        unique case (state_q)
            ST_IDLE: begin
                if (s5 && s10) begin
                    state_d = ST_REJECT;
                end else if (s5 || s10) begin
                    state_d = ST_QUAL;
                    type_d  = s5 ? COIN_5 : COIN_10;
                    cnt_d   = ONE;
                end
            end
            ST_QUAL: begin
                // A second sensor means two coins or a jam: reject wins over qualifying.
                if (other_hi) begin
                    state_d = ST_REJECT;
                end else if (!latched_hi) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == DEB_QUAL) begin
                    state_d = ST_EMIT;
                end else if (cnt_q != STUCK_MAX) begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_EMIT: begin
                if (bus.inhibit) begin
                    reject_d = 1'b1;
                end else begin
                    coin_d = type_q;
                end
                state_d = ST_RELEASE;
                cnt_d   = '0;
                stuck_d = '0;
            end
            ST_REJECT: begin
                reject_d = 1'b1;
                state_d  = ST_RELEASE;
                cnt_d    = '0;
                stuck_d  = '0;
            end
            ST_RELEASE: begin
                if (s5 || s10) begin
                    // Release debounce restarts; stuck time accumulates and saturates.
                    cnt_d = '0;
                    if (stuck_q != STUCK_MAX) begin
                        stuck_d = stuck_q + ONE;
                    end
                    if (stuck_d == STUCK_MAX) begin
                        fault_d = 1'b1;
                    end
                end else if (cnt_q == DEB_REL) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != STUCK_MAX) begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            stuck_q  <= '0;
            type_q   <= COIN_5;
            coin_q   <= COIN_NONE;
            reject_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stuck_q  <= stuck_d;
            type_q   <= type_d;
            coin_q   <= coin_d;
            reject_q <= reject_d;
            fault_q  <= fault_d;
        end
    end

    assign bus.coin   = coin_q;
    assign bus.reject = reject_q;
    assign bus.fault  = fault_q;
endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - scoreboard bench for coin_acceptor
module tb_coin_acceptor;
    import coin_acceptor_pkg::*;

    logic clk;
    logic rst;

    coin_acceptor_if bus ();

    coin_acceptor #(
        .DEBOUNCE_CYCLES (16),
        .STUCK_CYCLES    (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] coin;
        logic       reject;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] c, input logic r, input int at);
        exp_t e;
        e.coin   = c;
        e.reject = r;
        e.cyc    = at;
        sb.push_back(e);
    endtask

    // One clock: count the edge, then sample outputs on the falling edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (bus.coin !== 2'b00 || bus.reject !== 1'b0) begin
            check("coin_reject_exclusive", 32'(bus.coin != 2'b00 && bus.reject), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_output", {29'd0, bus.coin, bus.reject}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("out_coin",   32'(bus.coin),   32'(e.coin));
                check("out_reject", 32'(bus.reject), 32'(e.reject));
                check("out_cycle",  32'(cyc),        32'(e.cyc));
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_drained"}, 32'(sb.size()), 32'd0);
        check({tag, "_idle"}, 32'(dut.state_q), 32'(ST_IDLE));
    endtask

    initial begin
        rst            = 1'b1;
        bus.coin5_raw  = 1'b0;
        bus.coin10_raw = 1'b0;
        bus.inhibit    = 1'b0;
        run(3);
        check("rst_coin",   32'(bus.coin),   32'd0);
        check("rst_reject", 32'(bus.reject), 32'd0);
        check("rst_fault",  32'(bus.fault),  32'd0);
        check("rst_state",  32'(dut.state_q), 32'(ST_IDLE));
        rst = 1'b0;
        run(3);

        // T1 clean 5-unit coin
        push(COIN_5, 1'b0, cyc + 20);
        bus.coin5_raw = 1'b1;
        run(40);
        bus.coin5_raw = 1'b0;
        run(25);
        expect_idle("t1");

        // T2 glitch on the 10 sensor
        bus.coin10_raw = 1'b1;
        run(10);
        bus.coin10_raw = 1'b0;
        run(25);
        expect_idle("t2");

        // T3 both sensors together
        push(COIN_NONE, 1'b1, cyc + 4);
        bus.coin5_raw  = 1'b1;
        bus.coin10_raw = 1'b1;
        run(40);
        bus.coin5_raw  = 1'b0;
        bus.coin10_raw = 1'b0;
        run(25);
        expect_idle("t3");

        // T4 inhibited 10 coin is rejected
        bus.inhibit = 1'b1;
        push(COIN_NONE, 1'b1, cyc + 20);
        bus.coin10_raw = 1'b1;
        run(40);
        bus.coin10_raw = 1'b0;
        run(25);
        expect_idle("t4a");

        // T4 inhibit only matters in EMIT: dropped mid-qualification, coin is accepted
        push(COIN_10, 1'b0, cyc + 20);
        bus.coin10_raw = 1'b1;
        run(10);
        bus.inhibit = 1'b0;
        run(30);
        bus.coin10_raw = 1'b0;
        run(25);
        expect_idle("t4b");

        // T5 stuck sensor
        push(COIN_5, 1'b0, cyc + 20);
        bus.coin5_raw = 1'b1;
        run(80);
        check("t5_fault_early", 32'(bus.fault), 32'd0);
        run(10);
        check("t5_fault_set", 32'(bus.fault), 32'd1);
        check("t5_in_release", 32'(dut.state_q), 32'(ST_RELEASE));
        run(110);
        bus.coin5_raw = 1'b0;
        run(25);
        expect_idle("t5");
        check("t5_fault_sticky", 32'(bus.fault), 32'd1);

        // Coins still accepted while fault is set
        push(COIN_5, 1'b0, cyc + 20);
        bus.coin5_raw = 1'b1;
        run(30);
        bus.coin5_raw = 1'b0;
        run(25);
        expect_idle("t5b");
        check("t5b_fault_sticky", 32'(bus.fault), 32'd1);

        // T6 reset eight cycles into qualification
        bus.coin5_raw = 1'b1;
        run(11);
        check("t6_in_qual", 32'(dut.state_q), 32'(ST_QUAL));
        rst = 1'b1;
        #1;
        check("t6_coin",   32'(bus.coin),   32'd0);
        check("t6_reject", 32'(bus.reject), 32'd0);
        check("t6_fault",  32'(bus.fault),  32'd0);
        check("t6_state",  32'(dut.state_q), 32'(ST_IDLE));
        bus.coin5_raw = 1'b0;
        run(2);
        rst = 1'b0;
        run(30);
        expect_idle("t6");
        check("t6_fault_after", 32'(bus.fault), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
